// File: rtl/ddr5_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr5_cmd_pkg (package)
//  Description : Shared DDR5 column-command encodings, FSM state encodings,
//                and the helpers that choose a command's data latency and
//                command code.
//  Contents    : CMD_* command codes, lat_t latency type, ST_* states,
//                sel_lat(), sel_cmd()
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr5_cmd_pkg;

  // Chip-select / command-bus codes driven on C_S
  localparam logic [3:0] CMD_RD  = 4'b0100;
  localparam logic [3:0] CMD_WR  = 4'b0111;
  localparam logic [3:0] CMD_RDA = 4'b1100;
  localparam logic [3:0] CMD_WRA = 4'b0101;
  localparam logic [3:0] CMD_DES = 4'b1111;

  // Latencies are small; 8 bits covers any sensible reservation depth
  localparam int LAT_W = 8;
  typedef logic [LAT_W-1:0] lat_t;

  // Scheduler FSM encodings
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SPACE = 1'b1;

  // Data latency of a command: auto-precharge selects the longer base
  // latency, and writes land two cycles earlier than reads.
  function automatic lat_t sel_lat(input logic is_wr, input logic ap,
                                   input int cl, input int cla);
    int base;
    base = ap ? cla : cl;
    if (is_wr) base = base - 2;
    return lat_t'(base);
  endfunction

  function automatic logic [3:0] sel_cmd(input logic is_wr, input logic ap);
    logic [3:0] code;
    if (is_wr) code = ap ? CMD_WRA : CMD_WR;
    else       code = ap ? CMD_RDA : CMD_RD;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rw_cmd_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : rw_cmd_sched_if (interface)
//  Description : Request/grant handshake and command/reservation outputs of
//                the read/write command scheduler.
//  Signals     : rd_req, wr_req   - level requests, held until granted
//                rd_ap, wr_ap     - auto-precharge qualifiers
//                rd_gnt, wr_gnt   - one-cycle grant pulses
//                C_S[3:0]         - issued command code (DES when idle)
//                slot_busy/slot_wr[CL_max-1:0] - data-slot reservation map
//  Modports    : master (requester side), slave (scheduler side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rw_cmd_sched_if #(
  parameter int CL_max = 10
) ();

  logic              rd_req;
  logic              wr_req;
  logic              rd_ap;
  logic              wr_ap;
  logic              rd_gnt;
  logic              wr_gnt;
  logic [3:0]        C_S;
  logic [CL_max-1:0] slot_busy;
  logic [CL_max-1:0] slot_wr;

  modport master (
    output rd_req, wr_req, rd_ap, wr_ap,
    input  rd_gnt, wr_gnt, C_S, slot_busy, slot_wr
  );

  modport slave (
    input  rd_req, wr_req, rd_ap, wr_ap,
    output rd_gnt, wr_gnt, C_S, slot_busy, slot_wr
  );

endinterface
`default_nettype wire

// File: rtl/slot_resv_map.sv
`default_nettype none
// ============================================================================
//  Module      : slot_resv_map
//  Description : Data-bus slot reservation map. Bit i of the map means the
//                data bus is booked i cycles after the current cycle. The map
//                shifts right every edge; eligibility of a read and a write
//                is judged against the shifted map, and an issued command
//                books BL_SLOTS slots starting at its latency.
//  Ports       : clk, rst (sync, active-low)
//                i_rd_lat, i_wr_lat   - latency of the pending read / write
//                i_issue_rd/wr        - command issued at this edge
//                o_rd_ok, o_wr_ok     - command would fit at this edge
//                o_busy, o_wr         - registered map (busy, direction)
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_resv_map
  import ddr5_cmd_pkg::*;
#(
  parameter int CL_max   = 10,
  parameter int BL_SLOTS = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire lat_t              i_rd_lat,
  input  wire lat_t              i_wr_lat,
  input  wire logic              i_issue_rd,
  input  wire logic              i_issue_wr,
  output logic                   o_rd_ok,
  output logic                   o_wr_ok,
  output logic [CL_max-1:0]      o_busy,
  output logic [CL_max-1:0]      o_wr
);

  localparam logic [CL_max-1:0] C_ONE   = {{(CL_max-1){1'b0}}, 1'b1};
  localparam logic [CL_max-1:0] C_BURST = {CL_max{1'b1}} >> (CL_max - BL_SLOTS);

  logic [CL_max-1:0] busy_q, busy_d;
  logic [CL_max-1:0] wr_q,   wr_d;
  logic [CL_max-1:0] s_busy, s_wr;

  // Burst slots must be free; the slot just before and just after the burst
  // must not carry the opposite direction (one-slot bus turnaround).
  function automatic logic fits(input logic is_wr, input lat_t lat,
                                input logic [CL_max-1:0] sb,
                                input logic [CL_max-1:0] sw);
    logic [CL_max-1:0] burst;
    logic [CL_max-1:0] edges;
    logic [CL_max-1:0] opp;
    burst = C_BURST << lat;
    edges = ((C_ONE << lat) >> 1) | (C_ONE << (lat + LAT_W'(BL_SLOTS)));
    opp   = is_wr ? (sb & ~sw) : (sb & sw);
    return ((sb & burst) == '0) && ((opp & edges) == '0);
  endfunction

  always_comb begin
    s_busy  = busy_q >> 1;
    s_wr    = wr_q   >> 1;
    o_rd_ok = fits(1'b0, i_rd_lat, s_busy, s_wr);
    o_wr_ok = fits(1'b1, i_wr_lat, s_busy, s_wr);
    busy_d  = s_busy;
    wr_d    = s_wr;
    if (i_issue_rd) begin
      busy_d = busy_d | (C_BURST << i_rd_lat);
    end
    if (i_issue_wr) begin
      busy_d = busy_d | (C_BURST << i_wr_lat);
      wr_d   = wr_d   | (C_BURST << i_wr_lat);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      wr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
    end
  end

  assign o_busy = busy_q;
  assign o_wr   = wr_q;

endmodule
`default_nettype wire

// File: rtl/rw_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rw_cmd_sched
//  Description : Read/write column-command scheduler. Arbitrates level
//                read/write requests round-robin, issues at most one command
//                per CCD cycles, and only when the command's data burst fits
//                the slot reservation map (including bus turnaround).
//  Ports       : clk              - rising-edge clock
//                rst              - synchronous active-low reset
//                bus (slave)      - rw_cmd_sched_if: requests, grants,
//                                   C_S command code, slot_busy / slot_wr
//  Parameters  : CL, CLA, CL_max, BL_SLOTS, CCD
//                Legal set: CLA+BL_SLOTS <= CL_max-1, CL >= 3, CCD >= 1
//  Macro       : AUTO_PRECHARGE_EN - when defined, rd_ap/wr_ap select
//                RDA/WRA with CLA / CLA-2 latency; otherwise ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module rw_cmd_sched
  import ddr5_cmd_pkg::*;
#(
  parameter int CL       = 4,
  parameter int CLA      = 6,
  parameter int CL_max   = 10,
  parameter int BL_SLOTS = 2,
  parameter int CCD      = 2
) (
  input  wire logic     clk,
  input  wire logic     rst,
  rw_cmd_sched_if.slave bus
);

  localparam int CNT_W = $clog2(CCD + 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             rr_wr_last_q, rr_wr_last_d;
  logic [3:0]       cs_q, cs_d;
  logic             rd_gnt_q, rd_gnt_d;
  logic             wr_gnt_q, wr_gnt_d;

  logic             rd_ap_eff, wr_ap_eff;
  lat_t             rd_lat, wr_lat;
  logic             rd_ok, wr_ok;
  logic             pick_rd, pick_wr;
  logic [CL_max-1:0] map_busy, map_wr;

`ifdef AUTO_PRECHARGE_EN
  assign rd_ap_eff = bus.rd_ap;
  assign wr_ap_eff = bus.wr_ap;
`else
  logic unused_ap;
  assign rd_ap_eff = 1'b0;
  assign wr_ap_eff = 1'b0;
  assign unused_ap = bus.rd_ap | bus.wr_ap;
`endif

  assign rd_lat = sel_lat(1'b0, rd_ap_eff, CL, CLA);
  assign wr_lat = sel_lat(1'b1, wr_ap_eff, CL, CLA);

  slot_resv_map #(
    .CL_max   (CL_max),
    .BL_SLOTS (BL_SLOTS)
  ) u_map (
    .clk        (clk),
    .rst        (rst),
    .i_rd_lat   (rd_lat),
    .i_wr_lat   (wr_lat),
    .i_issue_rd (pick_rd),
    .i_issue_wr (pick_wr),
    .o_rd_ok    (rd_ok),
    .o_wr_ok    (wr_ok),
    .o_busy     (map_busy),
    .o_wr       (map_wr)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rr_wr_last_q <= 1'b1;      // "write went last" so a read wins first
      cs_q         <= CMD_DES;
      rd_gnt_q     <= 1'b0;
      wr_gnt_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_wr_last_q <= rr_wr_last_d;
      cs_q         <= cs_d;
      rd_gnt_q     <= rd_gnt_d;
      wr_gnt_q     <= wr_gnt_d;
    end
  end

  // Next-state: spacing counter between issued commands
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // With CCD == 1 a command may issue every cycle, so no SPACE visit
        if ((pick_rd || pick_wr) && (CCD > 1)) begin
          state_d = ST_SPACE;
          cnt_d   = CNT_W'(CCD - 1);
        end
      end
      ST_SPACE: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: arbitration and registered command/grant values
  always_comb begin
    logic rd_cand;
    logic wr_cand;
    rd_cand      = (state_q == ST_IDLE) && bus.rd_req && rd_ok;
    wr_cand      = (state_q == ST_IDLE) && bus.wr_req && wr_ok;
    pick_rd      = 1'b0;
    pick_wr      = 1'b0;
    if (rd_cand && wr_cand) begin
      pick_rd = rr_wr_last_q;
      pick_wr = !rr_wr_last_q;
    end else begin
      pick_rd = rd_cand;
      pick_wr = wr_cand;
    end
    rr_wr_last_d = rr_wr_last_q;
    cs_d         = CMD_DES;
    if (pick_rd) begin
      rr_wr_last_d = 1'b0;
      cs_d         = sel_cmd(1'b0, rd_ap_eff);
    end else if (pick_wr) begin
      rr_wr_last_d = 1'b1;
      cs_d         = sel_cmd(1'b1, wr_ap_eff);
    end
    rd_gnt_d = pick_rd;
    wr_gnt_d = pick_wr;
  end

  assign bus.C_S       = cs_q;
  assign bus.rd_gnt    = rd_gnt_q;
  assign bus.wr_gnt    = wr_gnt_q;
  assign bus.slot_busy = map_busy;
  assign bus.slot_wr   = map_wr;

endmodule
`default_nettype wire

// File: tb/tb_rw_cmd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rw_cmd_sched
//  Description : Self-checking bench for rw_cmd_sched at default parameters.
//                Single-command vectors from reset go through a scoreboard
//                queue; multi-cycle sequences cover turnaround, round-robin,
//                spacing, slot collisions and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rw_cmd_sched;

  localparam int CL = 4, CLA = 6, CL_max = 10, BL_SLOTS = 2, CCD = 2;

  localparam logic [3:0] E_RD  = 4'b0100;
  localparam logic [3:0] E_WR  = 4'b0111;
  localparam logic [3:0] E_RDA = 4'b1100;
  localparam logic [3:0] E_WRA = 4'b0101;
  localparam logic [3:0] E_DES = 4'b1111;

`ifdef AUTO_PRECHARGE_EN
  localparam logic [3:0] E_RAP_CS   = E_RDA;
  localparam logic [9:0] E_RAP_BUSY = 10'b0011000000;
  localparam logic [3:0] E_WAP_CS   = E_WRA;
  localparam logic [9:0] E_WAP_BUSY = 10'b0000110000;
`else
  localparam logic [3:0] E_RAP_CS   = E_RD;
  localparam logic [9:0] E_RAP_BUSY = 10'b0000110000;
  localparam logic [3:0] E_WAP_CS   = E_WR;
  localparam logic [9:0] E_WAP_BUSY = 10'b0000001100;
`endif

  typedef struct packed {
    logic [3:0] cs;
    logic       rg;
    logic       wg;
    logic [9:0] busy;
    logic [9:0] wr;
  } obs_t;

  typedef struct {
    logic rd_req;
    logic wr_req;
    logic rd_ap;
    logic wr_ap;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  obs_t sb_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  rw_cmd_sched_if #(.CL_max(CL_max)) bus ();

  rw_cmd_sched #(
    .CL(CL), .CLA(CLA), .CL_max(CL_max), .BL_SLOTS(BL_SLOTS), .CCD(CCD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = {bus.C_S, bus.rd_gnt, bus.wr_gnt, bus.slot_busy, bus.slot_wr};
    return o;
  endfunction

  task automatic pop_cmp(input string name);
    obs_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %b expected an entry", name, observe());
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(observe()), 32'(e));
    end
  endtask

  task automatic drive(input logic rq, input logic wq, input logic ra, input logic wa);
    bus.rd_req = rq;
    bus.wr_req = wq;
    bus.rd_ap  = ra;
    bus.wr_ap  = wa;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic rq, input logic wq, input logic ra, input logic wa,
                              input logic [3:0] cs, input logic rg, input logic wg,
                              input logic [9:0] b, input logic [9:0] w);
    vec_t v;
    v.rd_req = rq;
    v.wr_req = wq;
    v.rd_ap  = ra;
    v.wr_ap  = wa;
    v.exp    = {cs, rg, wg, b, w};
    return v;
  endfunction

  // Absolute-cycle occupancy model for the free-running sequence
  logic occ_busy[64];
  logic occ_wr[64];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   got;
    int   first_rd;
    int   last_g;
    int   n_rd;
    int   lat;
    logic is_wr;
    logic conflict;
    logic [9:0] eb;
    logic [9:0] ew;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset state ----
    do_reset();
    chk("reset_state", 32'(observe()), 32'(obs_t'({E_DES, 1'b0, 1'b0, 10'b0, 10'b0})));

    // ---- single commands from reset ----
    vecs[0] = mk(0, 0, 0, 0, E_DES,    0, 0, 10'b0000000000, 10'b0000000000);
    vecs[1] = mk(1, 0, 0, 0, E_RD,     1, 0, 10'b0000110000, 10'b0000000000);
    vecs[2] = mk(0, 1, 0, 0, E_WR,     0, 1, 10'b0000001100, 10'b0000001100);
    vecs[3] = mk(1, 1, 0, 0, E_RD,     1, 0, 10'b0000110000, 10'b0000000000);
    vecs[4] = mk(1, 0, 1, 0, E_RAP_CS, 1, 0, E_RAP_BUSY,     10'b0000000000);
    vecs[5] = mk(0, 1, 0, 1, E_WAP_CS, 0, 1, E_WAP_BUSY,     E_WAP_BUSY);
    vecs[6] = mk(1, 1, 0, 1, E_RD,     1, 0, 10'b0000110000, 10'b0000000000);
    vecs[7] = mk(0, 0, 1, 1, E_DES,    0, 0, 10'b0000000000, 10'b0000000000);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      drive(vecs[v].rd_req, vecs[v].wr_req, vecs[v].rd_ap, vecs[v].wr_ap);
      sb_q.push_back(vecs[v].exp);
      // one cycle later the grant is gone, DES is driven and the map shifts
      sb_q.push_back({E_DES, 1'b0, 1'b0, vecs[v].exp.busy >> 1, vecs[v].exp.wr >> 1});
      tick();
      pop_cmp($sformatf("vec%0d_issue", v));
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      pop_cmp($sformatf("vec%0d_after", v));
    end

    // ---- read then write: write waits for the turnaround slot ----
    do_reset();
    drive(1, 0, 0, 0);
    tick();
    chk("turn_rd_gnt", 32'(bus.rd_gnt), 32'(1));
    drive(0, 1, 0, 0);
    got = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("rd_gnt_one_cycle", 32'(bus.rd_gnt), 32'(0));
      if (bus.wr_gnt) begin
        got = k;
        break;
      end
    end
    chk("turn_wr_gnt_cycle", 32'(got), 32'(5));
    chk("turn_map", 32'({bus.C_S, bus.slot_busy, bus.slot_wr}),
        32'({E_WR, 10'b0000001101, 10'b0000001100}));
    drive(0, 0, 0, 0);

    // ---- round robin: after a read, write wins a tie ----
    do_reset();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    repeat (8) tick();
    drive(1, 1, 0, 0);
    tick();
    chk("rr_after_rd", 32'({bus.C_S, bus.rd_gnt, bus.wr_gnt}), 32'({E_WR, 1'b0, 1'b1}));
    drive(0, 0, 0, 0);

    // ---- round robin after a write; no issue while spacing ----
    do_reset();
    drive(0, 1, 0, 0);
    tick();
    drive(1, 1, 0, 0);
    tick();
    chk("space_no_issue", 32'({bus.C_S, bus.rd_gnt, bus.wr_gnt}), 32'({E_DES, 1'b0, 1'b0}));
    tick();
    chk("rr_after_wr", 32'(observe()),
        32'(obs_t'({E_RD, 1'b1, 1'b0, 10'b0000110011, 10'b0000000011})));
    drive(0, 0, 0, 0);

    // ---- both held: spacing, legality, map vs independent occupancy ----
    // Back-to-back reads keep the bus booked at these parameters, so the
    // write never clears its turnaround gap and stays held off.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      occ_busy[i] = 1'b0;
      occ_wr[i]   = 1'b0;
    end
    last_g   = -100;
    first_rd = -1;
    n_rd     = 0;
    drive(1, 1, 0, 0);
    for (int t = 0; t < 30; t++) begin
      tick();
      if (bus.rd_gnt || bus.wr_gnt) begin
        is_wr = bus.wr_gnt;
        chk("held_one_grant", 32'(bus.rd_gnt & bus.wr_gnt), 32'(0));
        chk("held_spacing_ok", 32'((t - last_g) >= CCD), 32'(1));
        case (bus.C_S)
          E_RD:    lat = CL;
          E_WR:    lat = CL - 2;
          E_RDA:   lat = CLA;
          E_WRA:   lat = CLA - 2;
          default: lat = -1;
        endcase
        chk("held_code_ok", 32'((lat > 0) && (is_wr == (bus.C_S == E_WR || bus.C_S == E_WRA))), 32'(1));
        if (lat > 0) begin
          conflict = 1'b0;
          for (int k = 0; k < BL_SLOTS; k++)
            if (occ_busy[t + lat + k]) conflict = 1'b1;
          if (occ_busy[t + lat - 1] && (occ_wr[t + lat - 1] != is_wr)) conflict = 1'b1;
          if (occ_busy[t + lat + BL_SLOTS] && (occ_wr[t + lat + BL_SLOTS] != is_wr)) conflict = 1'b1;
          chk("held_slot_collision", 32'(conflict), 32'(0));
          for (int k = 0; k < BL_SLOTS; k++) begin
            occ_busy[t + lat + k] = 1'b1;
            occ_wr[t + lat + k]   = is_wr;
          end
        end
        if (!is_wr) begin
          n_rd++;
          if (first_rd < 0) first_rd = t;
        end
        last_g = t;
      end
      for (int i = 0; i < 10; i++) begin
        eb[i] = occ_busy[t + i];
        ew[i] = occ_wr[t + i];
      end
      chk($sformatf("held_map_t%0d", t), 32'({bus.slot_busy, bus.slot_wr}), 32'({eb, ew}));
    end
    chk("held_first_rd_cycle", 32'(first_rd), 32'(0));
    chk("held_rd_count", 32'(n_rd), 32'(15));
    drive(0, 0, 0, 0);

    // ---- reset mid-operation clears map, spacing and pointer ----
    do_reset();
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("midrst_clear", 32'(observe()), 32'(obs_t'({E_DES, 1'b0, 1'b0, 10'b0, 10'b0})));
    rst = 1'b1;
    drive(1, 1, 0, 0);
    tick();
    chk("midrst_rd_first", 32'(observe()),
        32'(obs_t'({E_RD, 1'b1, 1'b0, 10'b0000110000, 10'b0000000000})));
    drive(0, 0, 0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
